conv_encoder_k3: RTL
====================

// Module: conv_encoder_k3
// PURPOSE
//  Rate-1/2, constraint-length-3 convolutional encoder (generators G1=5 octal/101, G0=7 octal/111).
//  Produces the 2*DATA_W-bit codeword that the 4-bit Viterbi decoding block consumes.
//  Sits upstream of the channel model / decoder in the coding test path.
//  Accepts one data word per handshake, encodes serially (1 bit/cycle) and holds the codeword until taken.
// PARAMETERS
//  DATA_W      4  info bits per word; codeword width is 2*DATA_W
//  STATE_CARRY 0  0: trellis state cleared to 0 at every word accept; 1: state carried across words
// PORTS
//  clk        in   1         clock; all logic on rising edge
//  rst_n      in   1         reset; asynchronous, active-low
//  in_valid   in   1         in_data valid
//  in_data    in   DATA_W    info word; bit DATA_W-1 encoded first
//  in_ready   out  1         encoder can accept a word (IDLE only)
//  out_valid  out  1         out_code valid and stable
//  out_code   out  2*DATA_W  codeword; pair k at [2k+1:2k], k=0 from first bit encoded
//  out_ready  in   1         sink accepts out_code
//  busy       out  1         high in ENC or HOLD
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, in_ready=1, out_valid=0, out_code=0, busy=0,
//   trellis reg {s1,s0}=00, bit counter=0, data shift reg=0. Effective immediately, any state.
//  Encoding per bit u (u = current MSB of data shift reg):
//   out pair [1]=u^s1, [0]=u^s0^s1; then s1<=s0, s0<=u.
//   This is the same next-state map as the decoder trellis, next={s0,u}; the first pair is LSB-aligned.
//  FSM:
//   IDLE: in_ready=1.
//    On in_valid: latch in_data, counter<=0, clear {s1,s0} if STATE_CARRY=0, go to ENC.
//   ENC: in_ready=0. Each cycle encode one bit into out_code[2k+1:2k] (k=counter),
//    shift data left 1, counter++. After the DATA_W-th bit go to HOLD with out_valid=1.
//   HOLD: out_valid=1, out_code frozen, in_valid ignored.
//    On out_ready: out_valid<=0 and go to IDLE. out_code keeps its last value.
//  Latency: word accepted at edge N -> out_valid high after edge N+DATA_W.
//   Throughput: 1 word per DATA_W+2 cycles when out_ready is held high.
//  out_ready while in IDLE or ENC: ignored. in_valid while in ENC or HOLD: ignored (in_ready=0).
//  No pass-through: HOLD->IDLE and a new accept never occur in the same cycle.
//  Counter width is clog2(DATA_W)+1. No wrap occurs; the ENC exit is at counter==DATA_W-1.
//  No tail bits are appended; the decoder chooses the min-cost final state.
// TESTING
//  1 reset: assert rst_n=0 mid-ENC -> out_valid=0, in_ready=1, out_code=0 with no clock edge needed.
//  2 in_data=4'b0000 -> out_code=8'h00 exactly 4 cycles after accept.
//  3 in_data=4'b1011 -> out_code=8'h87 (pairs 11,01,00,10). in_data=4'b1000 -> 8'h37.
//  4 in_data=4'b1111 -> out_code=8'h5B.
//    Hold out_ready=0 for 10 cycles: out_code stable, in_ready=0.
//    Toggling in_valid in this window has no effect.
//  5 back-to-back words 1011 then 1111, out_ready=1 -> 8'h87 then 8'h5B (STATE_CARRY=0).
//    Check the accept-to-accept gap is 6 cycles.
//  6 loopback: feed every 4-bit word through this block, flip <=1 code bit, run the Viterbi decoder
//    -> decoder OutputData equals the original word for all 16 words.

Source files
------------

// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder (G1=101, G0=111). The encoder accepts one word,
// encodes it serially at one bit per cycle, and then holds the codeword until the sink takes it.
module conv_encoder_k3 #(
  parameter int unsigned DATA_W      = 4,
  parameter bit          STATE_CARRY = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   out_code,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int unsigned CODE_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   data_sr;
  logic [CNT_W-1:0]    cnt;
  logic                s1;
  logic                s0;
  logic                u_c;
  logic [1:0]          pair_c;

  // Current info bit and its output pair: [1] = u^s1 (G1), [0] = u^s0^s1 (G0).
  assign u_c    = data_sr[DATA_W-1];
  assign pair_c = {u_c ^ s1, u_c ^ s0 ^ s1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_code  <= '0;
      busy      <= 1'b0;
      data_sr   <= '0;
      cnt       <= '0;
      s1        <= 1'b0;
      s0        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_sr  <= in_data;
            cnt      <= '0;
            if (!STATE_CARRY) begin
              s1 <= 1'b0;
              s0 <= 1'b0;
            end
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ENC;
          end
        end
        ENC: begin
          for (int k = 0; k < int'(DATA_W); k++) begin
            if (cnt == CNT_W'(k)) out_code[2*k +: 2] <= pair_c;
          end
          data_sr <= data_sr << 1;
          s1      <= s0;
          s0      <= u_c;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W - 1)) begin
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // The IDLE return costs one cycle, so a new word is never accepted on the release edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  logic unused_c;
  assign unused_c = ^{CODE_W};

endmodule
